sample_trigger_scheduler: RTL and testbench

//  Turns raw drum-pad levels into one-at-a-time, handshaked sample-start requests for the audio mixer.

---
 rtl/audio_pkg.sv | 29 ++
 rtl/sample_trigger_scheduler_rr_pick.sv | 32 +++
 rtl/sample_trigger_scheduler.sv | 144 ++++++++++++++
 tb/tb_sample_trigger_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared pad/sample constants and trigger FSM encoding
package audio_pkg;

   localparam int NUM_PADS_DEF       = 4;
   localparam int SYNC_STAGES_DEF    = 2;
   localparam int HOLDOFF_CYCLES_DEF = 50000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      GAP   = 2'd2
   } trig_state_t;

   // Slot indices into the mixer's sample table.
   localparam int SAMPLE_KICK  = 0;
   localparam int SAMPLE_SNARE = 1;
   localparam int SAMPLE_HIHAT = 2;
   localparam int SAMPLE_TOM   = 3;

   function automatic int onehot_to_idx(input logic [31:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/sample_trigger_scheduler_rr_pick.sv
// rtl/sample_trigger_scheduler_rr_pick.sv - combinational round-robin finder:
// one-hot grant of the first requester at or after ptr, wrapping.
module rr_pick
   import audio_pkg::*;
#(
   parameter int NUM_PADS = NUM_PADS_DEF,
   parameter int PTR_W    = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
   input  logic [NUM_PADS-1:0] req,
   input  logic [PTR_W-1:0]    ptr,
   output logic [NUM_PADS-1:0] grant,
   output logic                any
);

   logic [PTR_W-1:0] w_idx;

   // Walk offsets from farthest to nearest so the closest requester wins.
   always_comb begin
      grant = '0;
      w_idx = '0;
      for (int k = NUM_PADS - 1; k >= 0; k--) begin
         w_idx = PTR_W'((int'(ptr) + k) % NUM_PADS);
         if (req[w_idx]) begin
            grant        = '0;
            grant[w_idx] = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/sample_trigger_scheduler.sv
// rtl/sample_trigger_scheduler.sv - pad sync/edge detect, one pending hit per pad,
// round-robin handshaked trigger offers; optional holdoff via TRIGGER_HOLDOFF_EN.
module sample_trigger_scheduler
   import audio_pkg::*;
#(
   parameter int NUM_PADS       = NUM_PADS_DEF,
   parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
   parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_PADS-1:0] pad_in,
   input  logic                trig_ready,
   output logic                trig_valid,
   output logic [NUM_PADS-1:0] trig_sel,
   output logic [NUM_PADS-1:0] pending,
   output logic                dropped
);

   localparam int PTR_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

   logic [NUM_PADS-1:0] r_sync [SYNC_STAGES];
   logic [NUM_PADS-1:0] r_prev;
   logic [NUM_PADS-1:0] r_pending;
   logic [NUM_PADS-1:0] r_grant;
   logic [PTR_W-1:0]    r_rr_ptr;
   logic                r_dropped;
   trig_state_t         r_state;
   trig_state_t         w_state_nxt;

   logic [NUM_PADS-1:0] w_edge;
   logic [NUM_PADS-1:0] w_pick;
   logic                w_any;
   logic                w_latch;
   logic                w_handshake;
   logic [NUM_PADS-1:0] w_clear;
   logic [NUM_PADS-1:0] w_blocked;
   logic [NUM_PADS-1:0] w_accept;
   logic [NUM_PADS-1:0] w_coalesce;
   logic [PTR_W-1:0]    w_grant_idx;
   logic [PTR_W-1:0]    w_ptr_nxt;

   // Reset to ones so a pad held down across reset release is not seen as a hit.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
         r_prev <= '1;
      end else begin
         r_sync[0] <= pad_in;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

   rr_pick #(
      .NUM_PADS (NUM_PADS),
      .PTR_W    (PTR_W)
   ) u_rr_pick (
      .req   (r_pending),
      .ptr   (r_rr_ptr),
      .grant (w_pick),
      .any   (w_any)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_handshake = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = OFFER;
               w_latch     = 1'b1;
            end
         end
         OFFER: begin
            if (trig_ready) begin
               w_state_nxt = GAP;
               w_handshake = 1'b1;
            end
         end
         GAP:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_clear     = w_handshake ? r_grant : '0;
   assign w_grant_idx = PTR_W'(onehot_to_idx(32'(r_grant)));
   assign w_ptr_nxt   = (w_grant_idx == PTR_W'(NUM_PADS - 1)) ? '0 : w_grant_idx + 1'b1;

`ifdef TRIGGER_HOLDOFF_EN
   localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

   logic [HOLD_W-1:0] r_hold [NUM_PADS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < NUM_PADS; p++) r_hold[p] <= '0;
      end else begin
         for (int p = 0; p < NUM_PADS; p++) begin
            if (w_clear[p]) r_hold[p] <= HOLD_W'(HOLDOFF_CYCLES);
            else if (r_hold[p] != '0) r_hold[p] <= r_hold[p] - 1'b1;
         end
      end
   end

   // A hit landing in the grant's own handshake cycle counts as inside the lockout.
   always_comb begin
      w_blocked = '0;
      for (int p = 0; p < NUM_PADS; p++) begin
         w_blocked[p] = w_edge[p] & ((r_hold[p] != '0) | w_clear[p]);
      end
   end
`else
   assign w_blocked = '0;
`endif

   assign w_accept   = w_edge & ~w_blocked;
   assign w_coalesce = w_accept & r_pending & ~w_clear;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_grant   <= '0;
         r_rr_ptr  <= '0;
         r_dropped <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= (r_pending & ~w_clear) | w_accept;
         r_dropped <= |(w_coalesce | w_blocked);
         if (w_latch) r_grant <= w_pick;
         if (w_handshake) r_rr_ptr <= w_ptr_nxt;
      end
   end

   assign trig_valid = (r_state == OFFER);
   assign trig_sel   = trig_valid ? r_grant : '0;
   assign pending    = r_pending;
   assign dropped    = r_dropped;

endmodule

// File: tb/tb_sample_trigger_scheduler.sv
// tb/tb_sample_trigger_scheduler.sv - bench for sample_trigger_scheduler
module tb_sample_trigger_scheduler;

   localparam int N    = 4;
   localparam int S    = 2;
   localparam int HOLD = 20;
`ifdef TRIGGER_HOLDOFF_EN
   localparam int EXP_EARLY_DROPS  = 1;
   localparam int EXP_EARLY_GRANTS = 0;
`else
   localparam int EXP_EARLY_DROPS  = 0;
   localparam int EXP_EARLY_GRANTS = 1;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] pad_in = '0;
   logic         trig_ready = 1'b0;
   logic         trig_valid;
   logic [N-1:0] trig_sel;
   logic [N-1:0] pending;
   logic         dropped;

   int checks = 0;
   int failures = 0;

   sample_trigger_scheduler #(
      .NUM_PADS       (N),
      .SYNC_STAGES    (S),
      .HOLDOFF_CYCLES (HOLD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pad_in     (pad_in),
      .trig_ready (trig_ready),
      .trig_valid (trig_valid),
      .trig_sel   (trig_sel),
      .pending    (pending),
      .dropped    (dropped)
   );

   always #5 clk = ~clk;

   // Reference model: pad history, one queued hit per pad, single offer with a
   // one-cycle gap after each accepted grant, round-robin by modulo search.
   logic [N-1:0] m_hist [0:S];
   logic [N-1:0] m_pend = '0;
   logic [N-1:0] m_edge, m_clr, m_blk, m_acc, m_old;
   bit           m_offer = 0, m_gap = 0, m_drop = 0, m_hs;
   int           m_grant = 0, m_ptr = 0;
   int           m_hold [N];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i <= S; i++) m_hist[i] = '1;
         m_pend = '0; m_offer = 0; m_gap = 0; m_drop = 0; m_grant = 0; m_ptr = 0;
         for (int p = 0; p < N; p++) m_hold[p] = 0;
      end else begin
         m_edge = m_hist[S-1] & ~m_hist[S];
         m_hs   = m_offer && trig_ready;
         m_clr  = m_hs ? N'(1 << m_grant) : '0;
         m_blk  = '0;
`ifdef TRIGGER_HOLDOFF_EN
         for (int p = 0; p < N; p++)
            if (m_edge[p] && (m_hold[p] != 0 || m_clr[p])) m_blk[p] = 1'b1;
         for (int p = 0; p < N; p++) begin
            if (m_hs && p == m_grant) m_hold[p] = HOLD;
            else if (m_hold[p] > 0) m_hold[p] = m_hold[p] - 1;
         end
`endif
         m_acc  = m_edge & ~m_blk;
         m_drop = |((m_acc & m_pend & ~m_clr) | m_blk);
         m_old  = m_pend;
         m_pend = (m_pend & ~m_clr) | m_acc;
         if (m_offer) begin
            if (trig_ready) begin
               m_offer = 0; m_gap = 1; m_ptr = (m_grant + 1) % N;
            end
         end else if (m_gap) begin
            m_gap = 0;
         end else if (m_old != 0) begin
            m_offer = 1;
            for (int k = N - 1; k >= 0; k--)
               if (m_old[(m_ptr + k) % N]) m_grant = (m_ptr + k) % N;
         end
         for (int i = S; i >= 1; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = pad_in;
      end
   end

   task automatic do_reset();
      pad_in = '0; trig_ready = 1'b0; reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (S + 2) @(negedge clk);
   endtask

   task automatic wait_valid(input int max_cycles, output int n);
      n = 0;
      while (trig_valid !== 1'b1 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      pad_in = '1; trig_ready = 1'b1; reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (trig_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", trig_valid); end
      checks++; if (trig_sel !== '0) begin failures++; $display("FAIL reset_sel got=%b exp=0000", trig_sel); end
      checks++; if (pending !== '0) begin failures++; $display("FAIL reset_pending got=%b exp=0000", pending); end
      checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL reset_dropped got=%b exp=0", dropped); end
   endtask

   task automatic test_single_hit();
      int n;
      do_reset();
      trig_ready = 1'b1; pad_in = 4'b0001;
      @(negedge clk);
      pad_in = '0;
      wait_valid(20, n);
      checks++; if (n + 1 !== S + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", n + 1, S + 2); end
      checks++; if (trig_sel !== 4'b0001) begin failures++; $display("FAIL single_sel got=%b exp=0001", trig_sel); end
      @(negedge clk);
      checks++; if (trig_valid !== 1'b0) begin failures++; $display("FAIL single_handshake got=%b exp=0", trig_valid); end
      checks++; if (pending !== '0) begin failures++; $display("FAIL single_pending got=%b exp=0000", pending); end
   endtask

   task automatic test_back_to_back();
      int t, last, got;
      logic [N-1:0] exp_sel;
      do_reset();
      trig_ready = 1'b1; pad_in = '1;
      @(negedge clk);
      pad_in = '0;
      t = 1; last = -1; got = 0; exp_sel = 4'b0001;
      repeat (30) begin
         if (trig_valid === 1'b1) begin
            checks++; if (trig_sel !== exp_sel) begin failures++; $display("FAIL b2b_sel got=%b exp=%b", trig_sel, exp_sel); end
            if (got > 0) begin
               checks++; if (t - last !== 3) begin failures++; $display("FAIL b2b_spacing got=%0d exp=3", t - last); end
            end
            last = t; got++; exp_sel = exp_sel << 1;
         end
         @(negedge clk);
         t++;
      end
      checks++; if (got !== 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", got); end
   endtask

   task automatic test_coalesce();
      int n, bad, drops, grants;
      do_reset();
      trig_ready = 1'b0; pad_in = 4'b0100;
      @(negedge clk);
      pad_in = '0;
      wait_valid(20, n);
      checks++; if (trig_valid !== 1'b1) begin failures++; $display("FAIL coal_offer got=%b exp=1", trig_valid); end
      pad_in = 4'b0100;
      @(negedge clk);
      pad_in = '0;
      bad = 0; drops = 0;
      repeat (8) begin
         if (trig_valid !== 1'b1 || trig_sel !== 4'b0100) bad++;
         if (dropped === 1'b1) drops++;
         @(negedge clk);
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL coal_stable got=%0d unstable cycles exp=0", bad); end
      checks++; if (drops !== 1) begin failures++; $display("FAIL coal_dropped got=%0d exp=1", drops); end
      checks++; if (pending !== 4'b0100) begin failures++; $display("FAIL coal_pending got=%b exp=0100", pending); end
      trig_ready = 1'b1; grants = 0;
      repeat (15) begin
         if (trig_valid === 1'b1) grants++;
         @(negedge clk);
      end
      checks++; if (grants !== 1) begin failures++; $display("FAIL coal_grants got=%0d exp=1", grants); end
   endtask

   task automatic test_reset_mid_offer();
      int n, grants;
      do_reset();
      trig_ready = 1'b0; pad_in = 4'b0010;
      wait_valid(20, n);
      checks++; if (trig_sel !== 4'b0010) begin failures++; $display("FAIL rmo_sel got=%b exp=0010", trig_sel); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (trig_valid !== 1'b0) begin failures++; $display("FAIL rmo_valid got=%b exp=0", trig_valid); end
      checks++; if (pending !== '0) begin failures++; $display("FAIL rmo_pending got=%b exp=0000", pending); end
      reset = 1'b0; trig_ready = 1'b1; grants = 0;
      repeat (15) begin
         if (trig_valid === 1'b1) grants++;
         @(negedge clk);
      end
      checks++; if (grants !== 0) begin failures++; $display("FAIL rmo_held_pad got=%0d grants exp=0", grants); end
      pad_in = '0;
   endtask

   task automatic test_rr_order();
      int n, got;
      logic [N-1:0] exp_seq [3];
      exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0010;
      do_reset();
      trig_ready = 1'b1; pad_in = 4'b0010;
      @(negedge clk);
      pad_in = '0;
      wait_valid(20, n);
      @(negedge clk);
      trig_ready = 1'b0;
      repeat (2) @(negedge clk);
      pad_in = 4'b1011;
      @(negedge clk);
      pad_in = '0;
      wait_valid(20, n);
      trig_ready = 1'b1; got = 0;
      repeat (20) begin
         if (trig_valid === 1'b1) begin
            if (got < 3) begin
               checks++; if (trig_sel !== exp_seq[got]) begin failures++; $display("FAIL rr_order[%0d] got=%b exp=%b", got, trig_sel, exp_seq[got]); end
            end
            got++;
         end
         @(negedge clk);
      end
      checks++; if (got !== 3) begin failures++; $display("FAIL rr_count got=%0d exp=3", got); end
   endtask

   task automatic test_holdoff();
      int n, drops, grants;
      do_reset();
      trig_ready = 1'b1; pad_in = 4'b1000;
      @(negedge clk);
      pad_in = '0;
      wait_valid(20, n);
      checks++; if (trig_sel !== 4'b1000) begin failures++; $display("FAIL hold_first got=%b exp=1000", trig_sel); end
      repeat (10) @(negedge clk);
      pad_in = 4'b1000;
      @(negedge clk);
      pad_in = '0;
      drops = 0; grants = 0;
      repeat (12) begin
         if (dropped === 1'b1) drops++;
         if (trig_valid === 1'b1) grants++;
         @(negedge clk);
      end
      checks++; if (drops !== EXP_EARLY_DROPS) begin failures++; $display("FAIL hold_early_drop got=%0d exp=%0d", drops, EXP_EARLY_DROPS); end
      checks++; if (grants !== EXP_EARLY_GRANTS) begin failures++; $display("FAIL hold_early_grant got=%0d exp=%0d", grants, EXP_EARLY_GRANTS); end
      @(negedge clk);
      pad_in = 4'b1000;
      @(negedge clk);
      pad_in = '0;
      wait_valid(20, n);
      checks++; if (trig_valid !== 1'b1 || trig_sel !== 4'b1000) begin failures++; $display("FAIL hold_late_grant got=%b/%b exp=1/1000", trig_valid, trig_sel); end
   endtask

   task automatic test_random();
      logic [N-1:0] exp_sel;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         exp_sel = m_offer ? N'(1 << m_grant) : '0;
         checks++; if (trig_valid !== m_offer) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, trig_valid, m_offer); end
         checks++; if (trig_sel !== exp_sel) begin failures++; $display("FAIL rnd_sel cyc=%0d got=%b exp=%b", i, trig_sel, exp_sel); end
         checks++; if (pending !== m_pend) begin failures++; $display("FAIL rnd_pending cyc=%0d got=%b exp=%b", i, pending, m_pend); end
         checks++; if (dropped !== m_drop) begin failures++; $display("FAIL rnd_dropped cyc=%0d got=%b exp=%b", i, dropped, m_drop); end
         if ($urandom_range(0, 3) == 0) pad_in = N'($urandom);
         trig_ready = ($urandom_range(0, 2) != 0);
         reset = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      reset = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_hit();
      test_back_to_back();
      test_coalesce();
      test_reset_mid_offer();
      test_rr_order();
      test_holdoff();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
